wallace_cpa_pipe: RTL and testbench

Two-stage pipelined carry-propagate adder that consumes the redundant sum/carry rows (r1, r2) produced by wallace_tree_reduction and resolves them into the final 10-bit product of the 5x5 Wallace multiplier. It replaces the single-cycle ripple final adder with a split 5+5 ripple chain, registered at the split, and uses valid/ready handshakes on both sides. Throughput is one product per cycle, and the block can stall under downstream backpressure.

---
 rtl/wallace_pkg.sv | 10 +
 rtl/wallace_cpa_pipe_if.sv | 27 ++
 rtl/wallace_cpa_pipe_rca.sv | 23 ++
 rtl/wallace_cpa_pipe.sv | 91 +++++++++
 tb/tb_wallace_cpa_pipe.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wallace_pkg.sv
// Shared widths and types for the 5x5 Wallace multiplier and its final-adder pipeline.
package wallace_pkg;

  localparam int OPND_W = 5;
  localparam int PROD_W = 10;
  localparam int LO_W   = 5;

  typedef logic [PROD_W-1:0] prod_t;

endpackage : wallace_pkg

// File: rtl/wallace_cpa_pipe_if.sv
// Valid/ready input (r1/r2 rows) and output (product/cout) channels of the final-adder pipeline.
interface wallace_cpa_pipe_if
  import wallace_pkg::*;
#(
  parameter int W = PROD_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         cout;

  modport master (
    output in_valid, r1, r2, out_ready,
    input  in_ready, out_valid, product, cout
  );

  modport slave (
    input  in_valid, r1, r2, out_ready,
    output in_ready, out_valid, product, cout
  );

endinterface : wallace_cpa_pipe_if

// File: rtl/wallace_cpa_pipe_rca.sv
// Plain N-bit ripple-carry adder built from full-adder cells.
module rca_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[N];

endmodule : rca_nbit

// File: rtl/wallace_cpa_pipe.sv
// Two-stage carry-propagate adder: low half added in stage 1, high half plus carry in stage 2.
module wallace_cpa_pipe
  import wallace_pkg::*;
#(
  parameter int PROD_W = wallace_pkg::PROD_W,
  parameter int LO_W   = wallace_pkg::LO_W
) (
  input logic               clk,
  input logic               rst_n,
  wallace_cpa_pipe_if.slave bus
);

  localparam int HI_W = PROD_W - LO_W;

  logic              s1_adv_s;
  logic              s2_adv_s;
  logic [LO_W-1:0]   lo_sum_s;
  logic              lo_c_s;
  logic [HI_W-1:0]   hi_sum_s;
  logic              hi_c_s;

  logic              s1_valid_r;
  logic [LO_W-1:0]   lo_sum_r;
  logic              lo_c_r;
  logic [HI_W-1:0]   r1_hi_r;
  logic [HI_W-1:0]   r2_hi_r;

  logic              s2_valid_r;
  logic [PROD_W-1:0] product_r;
  logic              cout_r;

  rca_nbit #(.N(LO_W)) u_lo_add (
    .a    (bus.r1[LO_W-1:0]),
    .b    (bus.r2[LO_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_s),
    .cout (lo_c_s)
  );

  rca_nbit #(.N(HI_W)) u_hi_add (
    .a    (r1_hi_r),
    .b    (r2_hi_r),
    .cin  (lo_c_r),
    .sum  (hi_sum_s),
    .cout (hi_c_s)
  );

  // Ready chain: the only combinational path through the block is out_ready -> in_ready.
  always_comb begin
    s2_adv_s = 1'b0;
    s1_adv_s = 1'b0;
    s2_adv_s = !s2_valid_r || bus.out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
  end

  // Stage 1: capture low-half sum/carry and the untouched high halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      lo_sum_r   <= '0;
      lo_c_r     <= 1'b0;
      r1_hi_r    <= '0;
      r2_hi_r    <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      lo_sum_r   <= lo_sum_s;
      lo_c_r     <= lo_c_s;
      r1_hi_r    <= bus.r1[PROD_W-1:LO_W];
      r2_hi_r    <= bus.r2[PROD_W-1:LO_W];
    end
  end

  // Stage 2: resolve the high half and hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      product_r  <= '0;
      cout_r     <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      product_r  <= {hi_sum_s, lo_sum_r};
      cout_r     <= hi_c_s;
    end
  end

  assign bus.in_ready  = s1_adv_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.product   = product_r;
  assign bus.cout      = cout_r;

endmodule : wallace_cpa_pipe

// File: tb/tb_wallace_cpa_pipe.sv
// Directed bench for wallace_cpa_pipe: latency, carry boundaries, throughput, backpressure, reset.
module tb_wallace_cpa_pipe;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  wallace_cpa_pipe_if bus ();

  wallace_cpa_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.r1        = 10'd0;
    bus.r2        = 10'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.product !== 10'd0 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL reset_data: got product=%0d cout=%b expected 0/0", bus.product, bus.cout);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  // One isolated transfer with out_ready held high; checks 2-edge latency and 1-cycle valid.
  task automatic send_one(input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] exp_p, input logic exp_c, input string nm);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.r1        = a;
    bus.r2        = b;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", nm, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.r1       = 10'h2AA;
    bus.r2       = 10'h155;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early_valid: got %b expected 0", nm, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product !== exp_p || bus.cout !== exp_c) begin
      errors++;
      $display("FAIL %s_result: got valid=%b product=%h cout=%b expected valid=1 product=%h cout=%b",
               nm, bus.out_valid, bus.product, bus.cout, exp_p, exp_c);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_valid_width: got %b expected 0", nm, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    send_one(10'd10,  10'd5,   10'd15,  1'b0, "basic_add");
    send_one(10'h01F, 10'h001, 10'h020, 1'b0, "split_carry");
    send_one(10'h3FF, 10'h001, 10'h000, 1'b1, "full_wrap");
    send_one(10'h3FF, 10'h3FF, 10'h3FE, 1'b1, "max_plus_max");
  endtask

  task automatic test_back_to_back();
    logic [9:0] va [4] = '{10'd10, 10'd900, 10'd100, 10'd700};
    logic [9:0] vb [4] = '{10'd5,  10'd61,  10'd100, 10'd50};
    logic [9:0] ve [4] = '{10'd15, 10'd961, 10'd200, 10'd750};
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc < 4) begin
        bus.in_valid = 1'b1;
        bus.r1       = va[cyc];
        bus.r2       = vb[cyc];
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", cyc, bus.in_ready);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (cyc >= 2 && cyc < 6) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.product !== ve[cyc-2]) begin
          errors++;
          $display("FAIL b2b_out[%0d]: got valid=%b product=%0d expected valid=1 product=%0d",
                   cyc - 2, bus.out_valid, bus.product, ve[cyc-2]);
        end
      end else if (cyc == 6) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_drain: got valid=%b expected 0", bus.out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] va [3] = '{10'd1, 10'd20, 10'd300};
    logic [9:0] vb [3] = '{10'd2, 10'd30, 10'd400};
    logic       exp_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int         idx;
    int         accepted;
    idx      = 0;
    accepted = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.r1       = va[idx];
      bus.r2       = vb[idx];
      checks++;
      if (bus.in_ready !== exp_rdy[cyc]) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", cyc, bus.in_ready, exp_rdy[cyc]);
      end
      if (cyc >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.product !== 10'd3) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got valid=%b product=%0d expected valid=1 product=3",
                   cyc, bus.out_valid, bus.product);
        end
      end
      if (bus.in_ready === 1'b1) begin
        accepted++;
        if (idx < 2) idx++;
      end
    end
    checks++;
    if (accepted != 2) begin
      errors++; $display("FAIL bp_accept_count: got %0d expected 2", accepted);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product !== 10'd50) begin
      errors++; $display("FAIL bp_drain2: got valid=%b product=%0d expected valid=1 product=50",
                         bus.out_valid, bus.product);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product !== 10'd700) begin
      errors++; $display("FAIL bp_resume: got valid=%b product=%0d expected valid=1 product=700",
                         bus.out_valid, bus.product);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.r1       = 10'd11;
    bus.r2       = 10'd22;
    @(negedge clk);
    bus.r1 = 10'd33;
    bus.r2 = 10'd44;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full: got valid=%b ready=%b expected valid=1 ready=0",
                         bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got valid=%b ready=%b expected valid=0 ready=1",
                         bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_one(10'd123, 10'd456, 10'd579, 1'b0, "post_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wallace_cpa_pipe
